// File: rtl/audioport_pkg.sv
// Shared constants and types for the audio port; the ABUF entries configure the
// ping-pong sample buffer player.
package audioport_pkg;

   localparam int AUDIO_BUFFER_SIZE = 32;
   localparam int ABUF_CHANNELS     = 2;
   localparam int ABUF_DATA_WIDTH   = 24;
   localparam int ABUF_REGISTERS    = 2 * AUDIO_BUFFER_SIZE * ABUF_CHANNELS;

   typedef enum logic {ABUF_IDLE, ABUF_PLAY} abuf_state_t;

endpackage

// File: rtl/abuf_bank.sv
// Sample storage for both buffer halves: one word-wide write port, one frame-wide
// combinational read port selected by half and frame index, synchronous clear.
module abuf_bank
   import audioport_pkg::*;
#(
   parameter int CHANNELS    = ABUF_CHANNELS,
   parameter int BUFFER_SIZE = AUDIO_BUFFER_SIZE,
   parameter int DATA_WIDTH  = ABUF_DATA_WIDTH,
   localparam int WORDS      = 2 * BUFFER_SIZE * CHANNELS,
   localparam int AW         = $clog2(WORDS),
   localparam int IW         = $clog2(BUFFER_SIZE)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr_i,
   input  logic                           wr_en_i,
   input  logic [AW-1:0]                  wr_addr_i,
   input  logic [DATA_WIDTH-1:0]          wr_data_i,
   input  logic                           rd_half_i,
   input  logic [IW-1:0]                  rd_index_i,
   output logic [CHANNELS*DATA_WIDTH-1:0] rd_frame_o
);

   logic [DATA_WIDTH-1:0] mem_q [WORDS];
   logic [AW-1:0]         rd_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
      end else if (wr_en_i && (32'(wr_addr_i) < WORDS)) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Frames are stored channel-interleaved, so a frame is CHANNELS adjacent words.
   assign rd_base = AW'((32'(rd_half_i) * BUFFER_SIZE + 32'(rd_index_i)) * CHANNELS);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
         assign rd_frame_o[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_base + AW'(gi)];
      end
   endgenerate

endmodule

// File: rtl/abuf_player.sv
// Ping-pong audio buffer player: play/idle control, per-half fill flags, frame
// index, half-release interrupt and sticky underrun detection around abuf_bank.
module abuf_player
   import audioport_pkg::*;
#(
   parameter int CHANNELS    = ABUF_CHANNELS,
   parameter int BUFFER_SIZE = AUDIO_BUFFER_SIZE,
   parameter int DATA_WIDTH  = ABUF_DATA_WIDTH,
   localparam int WORDS      = 2 * BUFFER_SIZE * CHANNELS,
   localparam int HALF_WORDS = BUFFER_SIZE * CHANNELS,
   localparam int AW         = $clog2(WORDS),
   localparam int IW         = $clog2(BUFFER_SIZE)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_in,
   input  logic                           stop_in,
   input  logic                           clr_in,
   input  logic                           mono_in,
   input  logic                           wr_en_in,
   input  logic [AW-1:0]                  wr_addr_in,
   input  logic [DATA_WIDTH-1:0]          wr_data_in,
   input  logic                           tick_in,
   output logic [CHANNELS*DATA_WIDTH-1:0] audio_out,
   output logic                           audio_valid_out,
   output logic                           irq_out,
   output logic                           active_buf_out,
   output logic                           underrun_out,
   output logic                           play_out,
   output logic [IW-1:0]                  index_out
);

   abuf_state_t                    state_q, state_d;
   logic [IW-1:0]                  index_q, index_d;
   logic                           active_q, active_d;
   logic [1:0]                     full_q, full_d;
   logic                           underrun_q, underrun_d;
   logic                           silent_q, silent_d;
   logic [CHANNELS*DATA_WIDTH-1:0] audio_q, audio_d;
   logic                           valid_q, valid_d;
   logic                           irq_q, irq_d;

   logic [1:0]                     full_set;
   logic [1:0]                     full_clr;
   logic [CHANNELS*DATA_WIDTH-1:0] rd_frame;
   logic [CHANNELS*DATA_WIDTH-1:0] out_frame;

   abuf_bank #(
      .CHANNELS    (CHANNELS),
      .BUFFER_SIZE (BUFFER_SIZE),
      .DATA_WIDTH  (DATA_WIDTH)
   ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr_in),
      .wr_en_i    (wr_en_in),
      .wr_addr_i  (wr_addr_in),
      .wr_data_i  (wr_data_in),
      .rd_half_i  (active_q),
      .rd_index_i (index_q),
      .rd_frame_o (rd_frame)
   );

   assign full_set[0] = wr_en_in && (32'(wr_addr_in) == HALF_WORDS - 1);
   assign full_set[1] = wr_en_in && (32'(wr_addr_in) == 2 * HALF_WORDS - 1);

   // A half that was empty when it became active plays silence for its whole pass.
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_out
         assign out_frame[gi*DATA_WIDTH +: DATA_WIDTH] =
            silent_q ? '0 :
            (mono_in ? rd_frame[DATA_WIDTH-1:0] : rd_frame[gi*DATA_WIDTH +: DATA_WIDTH]);
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      active_d   = active_q;
      full_d     = full_q;
      underrun_d = underrun_q;
      silent_d   = silent_q;
      audio_d    = audio_q;
      valid_d    = 1'b0;
      irq_d      = 1'b0;
      full_clr   = 2'b00;

      if (clr_in) begin
         state_d    = ABUF_IDLE;
         index_d    = '0;
         active_d   = 1'b0;
         full_d     = 2'b00;
         underrun_d = 1'b0;
         silent_d   = 1'b0;
         audio_d    = '0;
      end else begin
         case (state_q)
            ABUF_IDLE: begin
               if (start_in) begin
                  state_d  = ABUF_PLAY;
                  index_d  = '0;
                  active_d = 1'b0;
                  silent_d = !full_q[0];
               end
            end
            ABUF_PLAY: begin
               if (stop_in) begin
                  state_d = ABUF_IDLE;
                  index_d = '0;
                  audio_d = '0;
               end else if (tick_in) begin
                  audio_d = out_frame;
                  valid_d = 1'b1;
                  index_d = index_q + IW'(1);
                  if (index_q == IW'(BUFFER_SIZE - 1)) begin
                     // Release the drained half; flags are judged before this cycle's write.
                     active_d           = ~active_q;
                     full_clr[active_q] = 1'b1;
                     irq_d              = 1'b1;
                     silent_d           = !full_q[~active_q];
                     if (!full_q[~active_q]) underrun_d = 1'b1;
                  end
               end
            end
            default: state_d = ABUF_IDLE;
         endcase
         full_d = (full_q & ~full_clr) | full_set;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ABUF_IDLE;
         index_q    <= '0;
         active_q   <= 1'b0;
         full_q     <= 2'b00;
         underrun_q <= 1'b0;
         silent_q   <= 1'b0;
         audio_q    <= '0;
         valid_q    <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         active_q   <= active_d;
         full_q     <= full_d;
         underrun_q <= underrun_d;
         silent_q   <= silent_d;
         audio_q    <= audio_d;
         valid_q    <= valid_d;
         irq_q      <= irq_d;
      end
   end

   assign audio_out       = audio_q;
   assign audio_valid_out = valid_q;
   assign irq_out         = irq_q;
   assign active_buf_out  = active_q;
   assign underrun_out    = underrun_q;
   assign play_out        = (state_q == ABUF_PLAY);
   assign index_out       = index_q;

endmodule

// File: tb/tb_abuf_player.sv
// Bench for abuf_player: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a frame-level behavioural model.
module tb_abuf_player;

   localparam int CH    = 2;
   localparam int BS    = 32;
   localparam int DW    = 24;
   localparam int HW    = BS * CH;
   localparam int WORDS = 2 * HW;
   localparam int AW    = $clog2(WORDS);
   localparam int IW    = $clog2(BS);

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start_in = 1'b0, stop_in = 1'b0, clr_in = 1'b0, mono_in = 1'b0;
   logic             wr_en_in = 1'b0;
   logic [AW-1:0]    wr_addr_in = '0;
   logic [DW-1:0]    wr_data_in = '0;
   logic             tick_in = 1'b0;
   logic [CH*DW-1:0] audio_out;
   logic             audio_valid_out, irq_out, active_buf_out, underrun_out, play_out;
   logic [IW-1:0]    index_out;

   always #5 clk = ~clk;

   abuf_player #(.CHANNELS(CH), .BUFFER_SIZE(BS), .DATA_WIDTH(DW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_in        (start_in),
      .stop_in         (stop_in),
      .clr_in          (clr_in),
      .mono_in         (mono_in),
      .wr_en_in        (wr_en_in),
      .wr_addr_in      (wr_addr_in),
      .wr_data_in      (wr_data_in),
      .tick_in         (tick_in),
      .audio_out       (audio_out),
      .audio_valid_out (audio_valid_out),
      .irq_out         (irq_out),
      .active_buf_out  (active_buf_out),
      .underrun_out    (underrun_out),
      .play_out        (play_out),
      .index_out       (index_out)
   );

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: sample memory, per-half full flags and the playback cursor.
   logic [DW-1:0]    m_mem [WORDS];
   bit               m_full [2];
   bit               m_play, m_half, m_silent, m_unr, m_valid, m_irq;
   int               m_idx;
   logic [CH*DW-1:0] m_audio;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/audio"},    64'(audio_out),       64'(m_audio));
      check({tag, "/valid"},    64'(audio_valid_out), 64'(m_valid));
      check({tag, "/irq"},      64'(irq_out),         64'(m_irq));
      check({tag, "/active"},   64'(active_buf_out),  64'(m_half));
      check({tag, "/underrun"}, 64'(underrun_out),    64'(m_unr));
      check({tag, "/play"},     64'(play_out),        64'(m_play));
      check({tag, "/index"},    64'(index_out),       64'(m_idx));
   endtask

   task automatic model_reset();
      foreach (m_mem[i]) m_mem[i] = '0;
      m_full[0] = 0; m_full[1] = 0;
      m_play = 0; m_half = 0; m_silent = 0; m_unr = 0; m_valid = 0; m_irq = 0;
      m_idx = 0; m_audio = '0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit cl, input bit mo,
                             input bit we, input int wa, input logic [DW-1:0] wd, input bit tk);
      m_valid = 0;
      m_irq   = 0;
      if (cl) begin
         model_reset();
         return;
      end
      if (!m_play) begin
         if (st) begin
            m_play = 1; m_idx = 0; m_half = 0; m_silent = !m_full[0];
         end
      end else if (sp) begin
         m_play = 0; m_idx = 0; m_audio = '0;
      end else if (tk) begin
         for (int c = 0; c < CH; c++)
            m_audio[c*DW +: DW] = m_silent ? '0 : m_mem[int'(m_half)*HW + m_idx*CH + (mo ? 0 : c)];
         m_valid = 1;
         if (m_idx == BS - 1) begin
            m_irq = 1;
            m_full[m_half] = 0;
            m_half = !m_half;
            m_idx = 0;
            m_silent = !m_full[m_half];
            if (!m_full[m_half]) m_unr = 1;
         end else begin
            m_idx++;
         end
      end
      if (we && wa < WORDS) begin
         m_mem[wa] = wd;
         if (wa % HW == HW - 1) m_full[wa / HW] = 1;
      end
   endtask

   // One clock: apply inputs, step the model at the edge, compare just after it.
   task automatic drive(input bit st, input bit sp, input bit cl, input bit mo,
                        input bit we, input int wa, input logic [DW-1:0] wd, input bit tk);
      @(negedge clk);
      start_in = st; stop_in = sp; clr_in = cl; mono_in = mo;
      wr_en_in = we; wr_addr_in = AW'(wa); wr_data_in = wd; tick_in = tk;
      @(posedge clk);
      model_step(st, sp, cl, mo, we, wa, wd, tk);
      #1;
      check_all("cyc");
      start_in = 0; stop_in = 0; clr_in = 0; wr_en_in = 0; tick_in = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0, '0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fill_half(input int h, input bit rnd);
      for (int i = 0; i < HW; i++)
         drive(0, 0, 0, 0, 1, h*HW + i, rnd ? DW'($urandom) : DW'(h*HW + i), 0);
   endtask

   task automatic tick_n(input int n, input bit mo);
      repeat (n) begin
         drive(0, 0, 0, mo, 0, 0, '0, 1);
         drive(0, 0, 0, mo, 0, 0, '0, 0);
      end
   endtask

   initial begin
      int wp;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_all("por");
      @(negedge clk) rst_n = 1'b1;

      // Preloaded storage must be wiped by reset; first frame after start is silent.
      fill_half(0, 1);
      fill_half(1, 1);
      do_reset();
      drive(1, 0, 0, 0, 0, 0, '0, 0);
      drive(0, 0, 0, 0, 0, 0, '0, 1);
      check("rst_first_audio", 64'(audio_out), 64'd0);
      check("rst_first_valid", 64'(audio_valid_out), 64'd1);
      check("rst_first_unr", 64'(underrun_out), 64'd0);
      $display("phase reset-preload: %0d vectors", n_vec);

      drive(0, 0, 1, 0, 0, 0, '0, 0);
      fill_half(0, 0);
      drive(1, 0, 0, 0, 0, 0, '0, 0);
      drive(0, 0, 0, 0, 0, 0, '0, 1);
      check("fill0_audio", 64'(audio_out), 64'h000001_000000);
      check("fill0_index", 64'(index_out), 64'd1);
      $display("phase fill-half0: %0d vectors", n_vec);

      drive(0, 0, 1, 0, 0, 0, '0, 0);
      fill_half(0, 0);
      fill_half(1, 0);
      drive(1, 0, 0, 0, 0, 0, '0, 0);
      tick_n(31, 0);
      drive(0, 0, 0, 0, 0, 0, '0, 1);
      check("both_irq", 64'(irq_out), 64'd1);
      check("both_active", 64'(active_buf_out), 64'd1);
      check("both_unr", 64'(underrun_out), 64'd0);
      idle(1);
      drive(0, 0, 0, 0, 0, 0, '0, 1);
      check("both_h1f0", 64'(audio_out), 64'h000041_000040);
      $display("phase both-halves: %0d vectors", n_vec);

      drive(0, 0, 1, 0, 0, 0, '0, 0);
      fill_half(0, 1);
      drive(1, 0, 0, 0, 0, 0, '0, 0);
      tick_n(32, 0);
      check("udr_flag", 64'(underrun_out), 64'd1);
      drive(0, 0, 0, 0, 0, 0, '0, 1);
      check("udr_silent", 64'(audio_out), 64'd0);
      tick_n(5, 0);
      drive(0, 0, 1, 0, 0, 0, '0, 0);
      check("udr_clr_unr", 64'(underrun_out), 64'd0);
      check("udr_clr_play", 64'(play_out), 64'd0);
      $display("phase underrun: %0d vectors", n_vec);

      fill_half(0, 1);
      drive(0, 0, 0, 0, 1, 0, 24'h123456, 0);
      drive(0, 0, 0, 0, 1, 1, 24'hABCDEF, 0);
      drive(1, 0, 0, 0, 0, 0, '0, 0);
      drive(0, 0, 0, 1, 0, 0, '0, 1);
      check("mono_audio", 64'(audio_out), 64'h123456_123456);
      $display("phase mono: %0d vectors", n_vec);

      // Refill half 0's last word on the very tick that releases it.
      drive(0, 0, 1, 0, 0, 0, '0, 0);
      fill_half(0, 1);
      fill_half(1, 1);
      drive(1, 0, 0, 0, 0, 0, '0, 0);
      tick_n(31, 0);
      drive(0, 0, 0, 0, 1, HW - 1, DW'($urandom), 1);
      check("refill_irq", 64'(irq_out), 64'd1);
      idle(1);
      tick_n(32, 0);
      check("refill_back", 64'(active_buf_out), 64'd0);
      check("refill_unr", 64'(underrun_out), 64'd0);
      tick_n(3, 0);
      drive(0, 1, 0, 0, 0, 0, '0, 1);
      check("stoptick_valid", 64'(audio_valid_out), 64'd0);
      check("stoptick_play", 64'(play_out), 64'd0);
      drive(1, 0, 0, 0, 0, 0, '0, 0);
      check("restart_index", 64'(index_out), 64'd0);
      drive(0, 0, 0, 0, 0, 0, '0, 1);
      check("restart_idx1", 64'(index_out), 64'd1);
      $display("phase refill-stop: %0d vectors", n_vec);

      wp = 0;
      for (int i = 0; i < 4000; i++) begin
         int  r;
         bit  we, seq;
         int  wa;
         r   = $urandom_range(0, 199);
         we  = $urandom_range(0, 1) == 1;
         seq = $urandom_range(0, 3) != 0;
         wa  = seq ? wp : int'($urandom_range(0, WORDS - 1));
         if (we && seq) wp = (wp + 1) % WORDS;
         drive(r < 4, r >= 4 && r < 6, r == 6, $urandom_range(0, 3) == 0,
               we, wa, DW'($urandom), $urandom_range(0, 2) == 0);
      end
      $display("phase random: %0d vectors", n_vec);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/abuf_player.md
Name: abuf_player

Overview:
- Parametrised ping-pong audio buffer player: the successor to the fixed stereo ABUF0/ABUF1 bank.
- Generalised in channel count, buffer depth and sample width.
- Adds per-half fill tracking, a buffer-release interrupt, sticky underrun detection and a mono mode.
- Sits between the APB register decoder (write side) and the dsp_unit input (sample side); it is ticked by the sample-rate divider.

Parameters:
- CHANNELS, 2, audio channels per sample frame (>=1).
- BUFFER_SIZE, 32, sample frames per buffer half (power of 2, >=2).
- DATA_WIDTH, 24, bits per sample.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_in  in  1  one-cycle start command.
- stop_in  in  1  one-cycle stop command.
- clr_in  in  1  one-cycle clear command.
- mono_in  in  1  1 = mono mode: channel 0 is replicated to all outputs.
- wr_en_in  in  1  buffer write strobe.
- wr_addr_in  in  AW=$clog2(2*BUFFER_SIZE*CHANNELS)  word address.
- wr_data_in  in  DATA_WIDTH  write data.
- tick_in  in  1  one-cycle sample request.
- audio_out  out  CHANNELS*DATA_WIDTH  sample frame; channel 0 in the LSBs.
- audio_valid_out  out  1  one-cycle frame strobe.
- irq_out  out  1  one-cycle pulse when a half has been consumed.
- active_buf_out  out  1  half currently being read.
- underrun_out  out  1  sticky underrun flag.
- play_out  out  1  high in PLAY.
- index_out  out  $clog2(BUFFER_SIZE)  read frame index within the active half.

Behaviour:
- Reset (rst_n=0): all outputs 0; state IDLE; full[1:0]=0; storage zeroed.
- Address map: addr = half*BUFFER_SIZE*CHANNELS + frame*CHANNELS + ch.
- Writes with wr_addr_in >= 2*BUFFER_SIZE*CHANNELS are ignored.
- Writes are accepted in every state.
- Writing the last word of a half (frame BUFFER_SIZE-1, ch CHANNELS-1) sets full[half].
- States and transitions:
  - IDLE -> PLAY on start_in: index=0, active_buf=0, play_out=1 the next cycle.
  - PLAY -> IDLE on stop_in: index=0, audio_out cleared to 0.
  - start_in while in PLAY is ignored; stop_in while in IDLE is ignored.
- clr_in, any state: IDLE; storage, full, underrun, index, active_buf and audio_out all cleared in one cycle.
- Command priority: clr_in > stop_in > start_in. tick_in in the same cycle as stop_in or clr_in is ignored.
- tick_in in PLAY:
  - Next cycle, audio_out holds frame[index] of the active half and audio_valid_out=1 for one cycle (latency 1).
  - index increments.
  - Mono: every output lane equals ch 0 of that frame.
- If the active half was not full when it became active, its frames output as 0. Counting, irq_out and switching proceed normally.
- tick_in in IDLE: ignored; audio_out holds its value.
- Wrap (tick at index=BUFFER_SIZE-1):
  - index wraps to 0 and active_buf toggles.
  - full[old] is cleared.
  - irq_out pulses in the same cycle as audio_valid_out.
  - If full[new] is 0 (sampled before any same-cycle write), underrun_out is set; it stays set until clr_in or reset.
- A same-cycle set and clear of full[h] (refill completes as half h is released): set wins.
- start_in does not clear full flags or underrun_out.
- Arithmetic: index counts modulo BUFFER_SIZE. No sample arithmetic.
- tick_in spacing is at least 2 clk cycles by system contract. Back-to-back ticks are still serviced one per cycle.

Decomposition:
- audioport_pkg gains:
  - ABUF_CHANNELS=2, ABUF_DATA_WIDTH=24.
  - typedef enum logic {ABUF_IDLE, ABUF_PLAY} abuf_state_t.
  - ABUF_REGISTERS redefined as 2*AUDIO_BUFFER_SIZE*ABUF_CHANNELS.
- Sub-module abuf_bank: register-array storage with one write port, one frame-wide read port (read mux by half and index) and synchronous clear. abuf_player holds the FSM, full flags, index and the irq/underrun logic.

Test Plan:
- Reset with storage preloaded -> all outputs 0; first tick after start yields audio_out=0, audio_valid_out=1, underrun_out=0.
- Fill half 0 (addr 0..63) with value=addr, start, 1 tick -> audio_out={24'd1,24'd0}, valid 1 cycle after tick, index_out=1.
- Fill both halves, start, 32 ticks -> irq_out pulse on tick 32, active_buf_out=1, underrun_out=0; tick 33 returns frame 0 of half 1 (values 64,65).
- Fill half 0 only, 32 ticks -> underrun_out=1 at switch; next frames 0 while counting continues. clr_in -> underrun_out=0, play_out=0.
- mono_in=1, frame 0 = {ch0=24'h123456, ch1=24'hABCDEF}, 1 tick -> audio_out={24'h123456,24'h123456}.
- Refill half 0's last word in the same cycle as its release, then run to the next switch -> full[0] stays set; no underrun at the switch back to half 0. stop_in together with tick_in -> no valid pulse; stop then start replays from index 0.
